// File: rtl/gate_sweep_checker.sv
// Self-test harness for two-input bitwise gates: sweeps every {a,b} vector into an
// external gate, checks each response against a golden model of the selected op,
// and reports done/pass, a saturating mismatch count and the first failing vector.
module gate_sweep_checker #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned LAT   = 1,
  parameter int unsigned ERR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op_sel,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [2*WIDTH-1:0]   first_err
);

  localparam int unsigned VW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

  state_e               state_q;
  logic [2:0]           op_q;
  logic [VW-1:0]        cnt_q;
  logic [2:0]           drain_q;

  // Stage 0 is loaded on the same edge as a/b; the oldest stage lines up with dut_y.
  logic [LAT-1:0]       vld_q;
  logic [LAT*WIDTH-1:0] exp_q;
  logic [LAT*VW-1:0]    vec_q;
  logic [LAT:0]         vld_sh;
  logic [(LAT+1)*WIDTH-1:0] exp_sh;
  logic [(LAT+1)*VW-1:0]    vec_sh;

  logic                 issue;
  logic                 last_issued;
  logic                 mism;
  logic [WIDTH-1:0]     exp_new;
  logic [WIDTH-1:0]     exp_top;
  logic [VW-1:0]        vec_top;
  logic [ERR_W-1:0]     err_nxt;
  logic [VW-1:0]        first_nxt;

  function automatic logic [WIDTH-1:0] golden(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    unique case (op)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  // Vector issue, golden value for the next vector and the mismatch bookkeeping.
  always_comb begin
    last_issued = vld_q[0] && ({a, b} == '1);
    issue       = (state_q == StSweep) && !last_issued;
    exp_new     = golden(op_q, cnt_q[VW-1:WIDTH], cnt_q[WIDTH-1:0]);
    vld_sh      = {vld_q, issue};
    exp_sh      = {exp_q, exp_new};
    vec_sh      = {vec_q, cnt_q};
    exp_top     = exp_q[LAT*WIDTH-1 -: WIDTH];
    vec_top     = vec_q[LAT*VW-1 -: VW];
    mism        = vld_q[LAT-1] && (dut_y != exp_top);
    err_nxt     = err_cnt;
    first_nxt   = first_err;
    if (mism) begin
      if (err_cnt != '1) err_nxt = err_cnt + 1'b1;
      if (err_cnt == '0) first_nxt = vec_top;
    end
  end

  // Compare pipeline: expected value and vector travel alongside the DUT latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      exp_q <= '0;
      vec_q <= '0;
    end else begin
      vld_q <= vld_sh[LAT-1:0];
      exp_q <= exp_sh[LAT*WIDTH-1:0];
      vec_q <= vec_sh[LAT*VW-1:0];
    end
  end

  // Sweep FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      cnt_q     <= '0;
      drain_q   <= '0;
      a         <= '0;
      b         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      first_err <= '0;
    end else begin
      err_cnt   <= err_nxt;
      first_err <= first_nxt;
      if (issue) begin
        {a, b} <= cnt_q;
        cnt_q  <= cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q      <= op_sel;
            err_cnt   <= '0;
            first_err <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= StSweep;
          end
        end
        StSweep: begin
          if (last_issued) begin
            if (LAT == 1) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_nxt == '0);
            end else begin
              state_q <= StDrain;
              drain_q <= 3'(LAT - 2);
            end
          end
        end
        StDrain: begin
          if (drain_q == '0) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_nxt == '0);
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (2-bit/3-cycle/3-bit counter and
// 1-bit/combinational/16-bit counter) driven by a truth-table gate model with
// randomly planted output faults.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_v [2];
  logic [2:0] op_v    [2];
  logic [2:0] dut_op  [2];
  logic [1:0] flip    [2][16];

  // Instance A: WIDTH=2, LAT=3, ERR_W=3
  logic [1:0] a_a, b_a, y_a, y0_a, d1_a, d2_a;
  logic       busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [3:0] first_a;
  // Instance B: WIDTH=1, LAT=1, ERR_W=16
  logic       a_b, b_b, y_b;
  logic [1:0] y0_b;
  logic       busy_b, done_b, pass_b;
  logic [15:0] err_b;
  logic [1:0] first_b;

  gate_sweep_checker #(.WIDTH(2), .LAT(3), .ERR_W(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_sel(op_v[0]), .a(a_a), .b(b_a),
    .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err(first_a)
  );

  gate_sweep_checker #(.WIDTH(1), .LAT(1), .ERR_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_sel(op_v[1]), .a(a_b), .b(b_b),
    .dut_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err(first_b)
  );

  // Gate under test as a per-op truth table indexed by {x,y}.
  function automatic logic [1:0] gate_tt(input logic [2:0] op, input logic [1:0] x,
                                         input logic [1:0] y);
    logic [3:0] t;
    logic [1:0] r;
    case (op)
      3'd0:    t = 4'b1000;
      3'd1:    t = 4'b1110;
      3'd2:    t = 4'b0111;
      3'd3:    t = 4'b0001;
      3'd4:    t = 4'b0110;
      3'd5:    t = 4'b1001;
      3'd6:    t = 4'b0011;
      default: t = 4'b1100;
    endcase
    for (int i = 0; i < 2; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  always_comb begin
    y0_a = gate_tt(dut_op[0], a_a, b_a) ^ flip[0][{a_a, b_a}];
    y0_b = gate_tt(dut_op[1], {1'b0, a_b}, {1'b0, b_b}) ^ flip[1][{2'b00, a_b, b_b}];
    y_b  = y0_b[0];
    y_a  = d2_a;
  end

  // Instance A's gate has two register stages.
  always @(posedge clk) begin
    d1_a <= y0_a;
    d2_a <= d1_a;
  end

  // Observation mux for the instance currently under test.
  bit          cur = 1'b0;
  logic        o_busy, o_done, o_pass;
  logic [3:0]  o_ab;
  logic [15:0] o_err;
  logic [3:0]  o_first;
  always_comb begin
    o_busy  = cur ? busy_b : busy_a;
    o_done  = cur ? done_b : done_a;
    o_pass  = cur ? pass_b : pass_a;
    o_ab    = cur ? {2'b00, a_b, b_b} : {a_a, b_a};
    o_err   = cur ? err_b : {13'd0, err_a};
    o_first = cur ? {2'b00, first_b} : first_a;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete sweep; expectations come from the planted fault set.
  task automatic run_sweep(input bit s, input logic [2:0] op, input int nflt, input bit chaos);
    int w, l, n, sat, cnt_f, first, k;
    bit seen;
    w = s ? 1 : 2;
    l = s ? 1 : 3;
    n = 1 << (2 * w);
    sat = s ? 65535 : 7;
    cur = s;
    for (int i = 0; i < 16; i++) flip[s][i] = 2'b00;
    if (nflt >= n) begin
      for (int i = 0; i < n; i++) flip[s][i] = s ? 2'b01 : 2'($urandom_range(1, 3));
    end else begin
      for (int j = 0; j < nflt; j++)
        flip[s][4'($urandom_range(0, n - 1))] = s ? 2'b01 : 2'($urandom_range(1, 3));
    end
    cnt_f = 0;
    first = 0;
    seen  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (flip[s][i] != 2'b00) begin
        cnt_f++;
        if (!seen) first = i;
        seen = 1'b1;
      end
    end
    if (cnt_f > sat) cnt_f = sat;
    dut_op[s] = op;
    @(negedge clk);
    start_v[s] = 1'b1;
    op_v[s]    = op;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    check("start_busy", 32'(o_busy), 32'd1);
    check("start_clr_done", 32'(o_done), 32'd0);
    check("start_clr_err", 32'(o_err), 32'd0);
    k = 0;
    while (!o_done && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (k <= n) check("vector", 32'(o_ab), 32'(k - 1));
      if (chaos && k == 3) begin
        start_v[s] = 1'b1;
        op_v[s]    = ~op;
      end
      if (chaos && k == 4) start_v[s] = 1'b0;
    end
    check("done_latency", 32'(k), 32'(n + l));
    check("err_cnt", 32'(o_err), 32'(cnt_f));
    check("first_err", 32'(o_first), 32'(first));
    check("pass", 32'(o_pass), 32'(cnt_f == 0));
    check("busy_done", 32'(o_busy), 32'd0);
    check("ab_hold", 32'(o_ab), 32'(n - 1));
  endtask

  // Asynchronous reset while instance B is on vector 2.
  task automatic rst_test();
    cur = 1'b1;
    for (int i = 0; i < 16; i++) flip[1][i] = 2'b00;
    flip[1][0] = 2'b01;
    dut_op[1]  = 3'd2;
    @(negedge clk);
    start_v[1] = 1'b1;
    op_v[1]    = 3'd2;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_ab", 32'(o_ab), 32'd2);
    check("pre_rst_err", 32'(o_err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ab", 32'(o_ab), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_done", 32'(o_done), 32'd0);
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_first", 32'(o_first), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      op_v[s]    = 3'd0;
      dut_op[s]  = 3'd0;
      for (int i = 0; i < 16; i++) flip[s][i] = 2'b00;
    end
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    for (int s = 0; s < 2; s++) begin
      cur = bit'(s);
      #1;
      check("rst_ab", 32'(o_ab), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_pass", 32'(o_pass), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_first", 32'(o_first), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sweep(1'b1, 3'd2, 0, 1'b0);   // NAND, clean, combinational
    run_sweep(1'b1, 3'd2, 4, 1'b0);   // every vector wrong
    run_sweep(1'b0, 3'd4, 0, 1'b0);   // XOR, 3-cycle latency
    run_sweep(1'b0, 3'd0, 16, 1'b0);  // error counter saturates
    run_sweep(1'b0, 3'd1, 0, 1'b1);   // start/op change while busy ignored
    run_sweep(1'b0, 3'd5, 3, 1'b0);   // rerun from DONE
    rst_test();
    run_sweep(1'b1, 3'd6, 1, 1'b0);   // clean restart from IDLE
    for (int r = 0; r < 8; r++)
      run_sweep(bit'(r % 2), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), r == 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
